fifo_rd_sched: RTL and testbench

Read-side controller and arbiter for the async FIFO. It shares the single FIFO read port between NREQ consumers using round-robin priority, with a bounded burst per grant. It owns the read pointer (binary and gray) and computes empty and occupancy from the write pointer, which the 2-flop synchronizer has already brought into the read domain. It drives the registered-read FIFO memory address and enable, and returns the gray read pointer for synchronization into the write domain.

---
 rtl/fifo_rd_sched_if.sv | 29 ++
 rtl/fifo_rd_sched.sv | 132 +++++++++++++
 tb/tb_fifo_rd_sched.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_sched_if.sv
// Read-side FIFO bus: synchronized write pointer and consumer requests in,
// grants, memory read controls, status and read-data tagging out.
interface fifo_rd_sched_if #(
  parameter int ADRRSIZE = 3,
  parameter int IDW      = 2
);
  localparam int NREQ = 1 << IDW;

  logic [ADRRSIZE:0]   rq2_wptr;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     grant;
  logic                rinc;
  logic [ADRRSIZE-1:0] raddr;
  logic [ADRRSIZE:0]   rptr_gray;
  logic                rempty;
  logic [ADRRSIZE:0]   level;
  logic                rvalid;
  logic [IDW-1:0]      rvld_id;

  modport slave (
    input  rq2_wptr, req,
    output grant, rinc, raddr, rptr_gray, rempty, level, rvalid, rvld_id
  );

  modport master (
    output rq2_wptr, req,
    input  grant, rinc, raddr, rptr_gray, rempty, level, rvalid, rvld_id
  );
endinterface

// File: rtl/fifo_rd_sched.sv
// Async FIFO read-side controller: round-robin arbiter with bounded bursts,
// read pointer ownership, empty/occupancy tracking and read-data tagging.
//
// state | meaning
// IDLE  | no grant; pick next requester round-robin once data is present
// SERVE | grant held for cur; one read per cycle while req[cur] and data remain
module fifo_rd_sched #(
  parameter int ADRRSIZE = 3,
  parameter int IDW      = 2,
  parameter int BURST    = 2
) (
  input  logic            rclk,
  input  logic            rrst,
  fifo_rd_sched_if.slave  rd
);
  localparam int NREQ = 1 << IDW;
  localparam int PW   = ADRRSIZE + 1;
  localparam int CW   = (BURST > 1) ? $clog2(BURST + 1) : 1;

  typedef enum logic {IDLE, SERVE} state_t;

  state_t            state_q;
  logic [PW-1:0]     rbin_q;
  logic [PW-1:0]     rbin_d;
  logic [PW-1:0]     rgray_q;
  logic [PW-1:0]     rgray_d;
  logic              rempty_q;
  logic [NREQ-1:0]   grant_q;
  logic [IDW-1:0]    cur_q;
  logic [IDW-1:0]    rr_ptr_q;
  logic [CW-1:0]     burst_cnt_q;
  logic              rvalid_q;
  logic [IDW-1:0]    rvld_id_q;

  logic [PW-1:0]     wbin;
  logic [IDW-1:0]    pick;
  logic [IDW-1:0]    idx;
  logic              pick_vld;
  logic              rinc;
  logic              burst_last;

  always_comb begin
    wbin = '0;
    wbin[PW-1] = rd.rq2_wptr[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rd.rq2_wptr[i];
    end
  end

  // Search starts at rr_ptr and wraps naturally in IDW bits.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = rr_ptr_q + IDW'(k);
      if (!pick_vld && rd.req[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
    end
  end

  assign rinc       = (state_q == SERVE) && rd.req[cur_q] && !rempty_q;
  assign burst_last = (burst_cnt_q == CW'(BURST - 1));
  assign rbin_d     = rbin_q + PW'(rinc);
  assign rgray_d    = rbin_d ^ (rbin_d >> 1);

  always_ff @(posedge rclk) begin
    if (rrst) begin
      state_q     <= IDLE;
      rbin_q      <= '0;
      rgray_q     <= '0;
      rempty_q    <= 1'b1;
      grant_q     <= '0;
      cur_q       <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      rvalid_q    <= 1'b0;
      rvld_id_q   <= '0;
    end else begin
      rbin_q   <= rbin_d;
      rgray_q  <= rgray_d;
      rempty_q <= (rgray_d == rd.rq2_wptr);
      rvalid_q <= rinc;
      if (rinc) rvld_id_q <= cur_q;

      case (state_q)
        IDLE: begin
          grant_q     <= '0;
          burst_cnt_q <= '0;
          if (!rempty_q && pick_vld) begin
            cur_q   <= pick;
            grant_q <= NREQ'(1) << pick;
            state_q <= SERVE;
          end
        end
        SERVE: begin
          // A stall on empty keeps the grant: nobody else could read either.
          if (!rd.req[cur_q] || (rinc && burst_last)) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= cur_q + IDW'(1);
            burst_cnt_q <= '0;
          end else if (rinc) begin
            burst_cnt_q <= burst_cnt_q + CW'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign rd.grant     = grant_q;
  assign rd.rinc      = rinc;
  assign rd.raddr     = rbin_q[ADRRSIZE-1:0];
  assign rd.rptr_gray = rgray_q;
  assign rd.rempty    = rempty_q;
  assign rd.level     = wbin - rbin_q;
  assign rd.rvalid    = rvalid_q;
  assign rd.rvld_id   = rvld_id_q;

  a_no_underflow: assert property (@(posedge rclk) disable iff (rrst)
    rinc |-> !rempty_q);
  a_grant_onehot: assert property (@(posedge rclk) disable iff (rrst)
    $onehot0(grant_q));
  a_rinc_granted: assert property (@(posedge rclk) disable iff (rrst)
    rinc |-> grant_q[cur_q]);
endmodule

// File: tb/tb_fifo_rd_sched.sv
// Directed bench for fifo_rd_sched: reset, empty stall, single requester,
// round-robin rotation, pointer wrap, request drop and reset mid-burst.
module tb_fifo_rd_sched;
  logic rclk = 1'b0;
  logic rrst;

  int n_chk  = 0;
  int n_fail = 0;

  fifo_rd_sched_if #(.ADRRSIZE(3), .IDW(2)) bus ();

  fifo_rd_sched #(.ADRRSIZE(3), .IDW(2), .BURST(2)) dut (
    .rclk (rclk),
    .rrst (rrst),
    .rd   (bus)
  );

  always #5 rclk = ~rclk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  function automatic logic [3:0] g2b(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic do_reset();
    rrst = 1'b1;
    bus.req = '0;
    bus.rq2_wptr = '0;
    tick();
    rrst = 1'b0;
  endtask

  task automatic exp_cyc(input string tag, input int g, input int ri, input int ra,
                         input int rv, input int re, input int id);
    tick();
    check_val({tag, "_grant"},  32'(bus.grant),  32'(g));
    check_val({tag, "_rinc"},   32'(bus.rinc),   32'(ri));
    check_val({tag, "_raddr"},  32'(bus.raddr),  32'(ra));
    check_val({tag, "_rvalid"}, 32'(bus.rvalid), 32'(rv));
    check_val({tag, "_rempty"}, 32'(bus.rempty), 32'(re));
    if (rv != 0) check_val({tag, "_rvld_id"}, 32'(bus.rvld_id), 32'(id));
  endtask

  int        exp_rbin;
  int        wexp;
  int        n_reads;
  logic      prev_rinc;
  logic [3:0] prev_gray;

  task automatic wrap_mon(input int ncyc);
    for (int c = 0; c < ncyc; c++) begin
      tick();
      check_val("wrap_level", 32'(bus.level), 32'((wexp - exp_rbin) & 15));
      check_val("wrap_raddr", 32'(bus.raddr), 32'(exp_rbin & 7));
      check_val("wrap_gray_step", $countones(bus.rptr_gray ^ prev_gray), 32'(prev_rinc));
      check_val("wrap_underflow", 32'(bus.rinc && (exp_rbin == wexp)), 32'(0));
      if (bus.rinc) check_val("wrap_grant", 32'(bus.grant), 32'(1));
      prev_rinc = bus.rinc;
      prev_gray = bus.rptr_gray;
      if (bus.rinc) begin
        exp_rbin = (exp_rbin + 1) & 15;
        n_reads++;
      end
    end
  endtask

  initial begin
    logic [3:0] rnd_w;

    // Reset with arbitrary inputs
    rrst = 1'b1;
    bus.req = 4'($urandom_range(0, 15));
    rnd_w = 4'($urandom_range(0, 15));
    bus.rq2_wptr = rnd_w;
    tick();
    tick();
    check_val("rst_gray",   32'(bus.rptr_gray), 32'(0));
    check_val("rst_rempty", 32'(bus.rempty),    32'(1));
    check_val("rst_grant",  32'(bus.grant),     32'(0));
    check_val("rst_rinc",   32'(bus.rinc),      32'(0));
    check_val("rst_rvalid", 32'(bus.rvalid),    32'(0));
    check_val("rst_level",  32'(bus.level),     32'(g2b(rnd_w)));

    // Empty stall
    do_reset();
    bus.req = 4'b0001;
    for (int c = 0; c < 20; c++) begin
      tick();
      check_val("stall_grant", 32'(bus.grant), 32'(0));
      check_val("stall_rinc",  32'(bus.rinc),  32'(0));
    end

    // Single requester, three words
    do_reset();
    bus.rq2_wptr = 4'b0010;
    bus.req = 4'b0001;
    check_val("single_pre_rempty", 32'(bus.rempty), 32'(1));
    exp_cyc("single_e1", 0, 0, 0, 0, 0, 0);
    exp_cyc("single_e2", 1, 1, 0, 0, 0, 0);
    exp_cyc("single_e3", 1, 1, 1, 1, 0, 0);
    exp_cyc("single_e4", 0, 0, 2, 1, 0, 0);
    exp_cyc("single_e5", 1, 1, 2, 0, 0, 0);
    exp_cyc("single_e6", 1, 0, 3, 1, 1, 0);
    check_val("single_gray",  32'(bus.rptr_gray), 32'(4'b0010));
    check_val("single_level", 32'(bus.level),     32'(0));
    bus.req = 4'b0000;
    tick();

    // Round-robin across all four consumers, eight words
    do_reset();
    bus.rq2_wptr = 4'b1100;
    bus.req = 4'b1111;
    exp_cyc("rr_e1", 0, 0, 0, 0, 0, 0);
    for (int g = 0; g < 4; g++) begin
      exp_cyc("rr_rd0", 1 << g, 1, 2 * g, 0, 0, 0);
      exp_cyc("rr_rd1", 1 << g, 1, 2 * g + 1, 1, 0, g);
      exp_cyc("rr_gap", 0, 0, (2 * g + 2) & 7, 1, (g == 3) ? 1 : 0, g);
    end
    check_val("rr_gray",   32'(bus.rptr_gray), 32'(4'b1100));
    check_val("rr_rempty", 32'(bus.rempty),    32'(1));
    check_val("rr_level",  32'(bus.level),     32'(0));
    bus.req = 4'b0000;
    tick();

    // Wrap: fifteen words, then the sixteenth across the pointer wrap
    do_reset();
    exp_rbin = 0;
    n_reads = 0;
    prev_rinc = 1'b0;
    prev_gray = 4'b0000;
    bus.req = 4'b0001;
    bus.rq2_wptr = 4'b1000;
    wexp = 15;
    wrap_mon(30);
    check_val("wrap_reads15", 32'(n_reads), 32'(15));
    check_val("wrap_stall_gray", 32'(bus.rptr_gray), 32'(4'b1000));
    bus.rq2_wptr = 4'b0000;
    wexp = 0;
    wrap_mon(6);
    check_val("wrap_reads16", 32'(n_reads),      32'(16));
    check_val("wrap_gray0",   32'(bus.rptr_gray), 32'(0));
    check_val("wrap_rempty",  32'(bus.rempty),    32'(1));
    check_val("wrap_raddr0",  32'(bus.raddr),     32'(0));

    // Drop request after first read of a burst
    bus.rq2_wptr = 4'b0011;
    exp_cyc("drop_e1", 0, 0, 0, 0, 0, 0);
    exp_cyc("drop_e2", 1, 1, 0, 0, 0, 0);
    exp_cyc("drop_e3", 1, 1, 1, 1, 0, 0);
    bus.req = 4'b0000;
    #1;
    check_val("drop_rinc_now", 32'(bus.rinc), 32'(0));
    tick();
    check_val("drop_grant",  32'(bus.grant),  32'(0));
    check_val("drop_raddr",  32'(bus.raddr),  32'(1));
    check_val("drop_rvalid", 32'(bus.rvalid), 32'(0));
    check_val("drop_level",  32'(bus.level),  32'(1));

    // Reset during a read cycle
    bus.req = 4'b0001;
    tick();
    check_val("mrst_pre_rinc", 32'(bus.rinc), 32'(1));
    rrst = 1'b1;
    tick();
    check_val("mrst_grant",  32'(bus.grant),     32'(0));
    check_val("mrst_gray",   32'(bus.rptr_gray), 32'(0));
    check_val("mrst_rempty", 32'(bus.rempty),    32'(1));
    check_val("mrst_rvalid", 32'(bus.rvalid),    32'(0));
    check_val("mrst_rinc",   32'(bus.rinc),      32'(0));
    check_val("mrst_level",  32'(bus.level),     32'(2));
    rrst = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
